key_bank: RTL and testbench
===========================

Name: key_bank

Overview:
- Parametrised multi-slot key store; successor to the single 32-bit byte-loaded key register.
- Holds NUM_KEYS keys of KEY_BYTES bytes each.
- Keys are loaded byte-serially through a start/valid handshake with an auto-incrementing byte pointer; each slot carries a valid flag.
- Supports abort and whole-bank zeroize, and provides registered full-key and single-byte readout to the cipher datapath.

Parameters:
NUM_KEYS, 4, number of key slots (>=2)
KEY_BYTES, 4, bytes per key (>=2); key width = 8*KEY_BYTES
(derived, not overridable) SW = clog2(NUM_KEYS), BW = clog2(KEY_BYTES)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
din  in  8  key byte during load
din_valid  in  1  din valid this cycle
load_start  in  1  begin loading slot load_slot
load_slot  in  SW  target slot for load_start
abort  in  1  cancel load in progress
zeroize  in  1  clear all slots
rd_slot  in  SW  read slot select
rd_byte  in  BW  read byte select
key_out  out  8*KEY_BYTES  registered key of rd_slot
byte_out  out  8  registered byte rd_byte of rd_slot
key_valid  out  NUM_KEYS  per-slot valid flags
busy  out  1  high in LOAD or ZERO
load_done  out  1  one-cycle pulse: key fully loaded
load_err  out  1  one-cycle pulse: protocol violation

Behaviour:
- Reset is asynchronous and active-low.
  - On reset_n=0: all slot storage, key_valid, key_out, byte_out, load_done and load_err are cleared to 0.
  - State goes to IDLE; byte pointer and slot latch are cleared to 0.
- State machine has three states: IDLE, LOAD, ZERO.
- busy = (state != IDLE).
- Input priority each cycle: zeroize > abort > load_start > din_valid.
- IDLE:
  - load_start with load_slot < NUM_KEYS -> LOAD; latch the slot; ptr=0; key_valid[slot] cleared on that edge.
  - load_start with load_slot >= NUM_KEYS -> load_err pulse; remain in IDLE.
  - din_valid or abort in IDLE -> load_err pulse (abort in IDLE only); din ignored.
- LOAD:
  - On each din_valid, din is written to byte ptr of the latched slot and ptr increments.
  - Byte 0 = bits [7:0] (little-endian byte order).
  - The final byte (ptr == KEY_BYTES-1 with din_valid) is written and, on the same edge:
    - key_valid[slot] is set;
    - load_done pulses for one cycle on the next cycle;
    - state returns to IDLE.
  - Latency: load_done is asserted in the cycle after the last byte is accepted.
  - No timeout; gaps between bytes are allowed.
  - load_start in LOAD -> load_err pulse; ignored, and the load continues.
  - abort -> latched slot cleared to 0, key_valid stays 0, ptr=0, state IDLE.
  - abort wins over a same-cycle din_valid (that byte is dropped).
- ZERO (entered from any state on zeroize):
  - All key_valid bits clear on the entry edge.
  - One slot is cleared per cycle, index 0..NUM_KEYS-1; the state then returns to IDLE.
  - busy is high for exactly NUM_KEYS cycles.
  - zeroize during ZERO restarts the walk at slot 0.
  - load_start and din_valid during ZERO -> load_err pulse; ignored.
  - An interrupted LOAD produces no load_done.
- Read path:
  - One-cycle registered latency.
  - key_out <= key_valid[rd_slot] ? slot[rd_slot] : 0.
  - byte_out <= byte rd_byte of the same value.
  - rd_byte >= KEY_BYTES -> 0.
  - rd_slot >= NUM_KEYS -> 0.
  - Reads sample pre-edge state: a read of a slot that completes on the same edge returns 0, and the new key appears one cycle later.
- Other slots remain valid and readable during a LOAD of a different slot.
- load_done and load_err are never high in the same cycle as reset release.

Test Plan:
- Reset release, then load slot 2 with bytes 0xEF,0xBE,0xAD,0xDE (one per cycle) -> load_done pulse the cycle after the 4th byte; key_valid=4'b0100. With rd_slot=2 one cycle later, key_out=0xDEADBEEF; rd_byte=3 gives byte_out=0xDE.
- Load slot 1 = 0x11223344, then start reloading slot 1 and abort after 2 bytes -> key_valid[1]=0; key_out for slot 1 = 0; no load_done; a subsequent full load of 0xCAFEF00D succeeds.
- Load slots 0 and 3, then assert zeroize for 1 cycle -> key_valid=0 on the next edge; busy high for 4 cycles; all reads return 0; load_start during busy gives a load_err pulse.
- Protocol errors:
  - din_valid while IDLE -> load_err pulse; no state change.
  - load_start while in LOAD -> load_err pulse; the load completes normally with the original slot.
- Gapped load: bytes with 3 idle cycles between them -> correct key is assembled; busy stays high throughout.
- Async reset asserted mid-LOAD (between clock edges) -> all outputs 0 immediately; state IDLE after release; key_valid=0.

Source files
------------

// File: rtl/key_bank.sv
// Multi-slot key store: byte-serial loading per slot, abort, whole-bank zeroize,
// and registered full-key / single-byte readout for the cipher datapath.
module key_bank #(
   parameter int unsigned NUM_KEYS  = 4,
   parameter int unsigned KEY_BYTES = 4,
   localparam int unsigned SW = $clog2(NUM_KEYS),
   localparam int unsigned BW = $clog2(KEY_BYTES)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             din,
   input  logic                   din_valid,
   input  logic                   load_start,
   input  logic [SW-1:0]          load_slot,
   input  logic                   abort,
   input  logic                   zeroize,
   input  logic [SW-1:0]          rd_slot,
   input  logic [BW-1:0]          rd_byte,
   output logic [8*KEY_BYTES-1:0] key_out,
   output logic [7:0]             byte_out,
   output logic [NUM_KEYS-1:0]    key_valid,
   output logic                   busy,
   output logic                   load_done,
   output logic                   load_err
);

   typedef enum logic [1:0] {StIdle, StLoad, StZero} state_e;

   state_e                 state_q, state_d;
   logic [SW-1:0]          slot_q, slot_d;
   logic [BW-1:0]          ptr_q, ptr_d;
   logic [SW-1:0]          zidx_q, zidx_d;
   logic [NUM_KEYS-1:0]    valid_q, valid_d;
   logic [7:0]             mem_q [NUM_KEYS][KEY_BYTES];
   logic [8*KEY_BYTES-1:0] key_out_q, rd_key;
   logic [7:0]             byte_out_q, rd_byte_val;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   wr_en, clr_load, clr_zero;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      ptr_d    = ptr_q;
      zidx_d   = zidx_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      clr_load = 1'b0;
      clr_zero = 1'b0;
      if (zeroize) begin
         state_d = StZero;
         zidx_d  = '0;
         valid_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (abort) begin
                  err_d = 1'b1;
               end else if (load_start) begin
                  if (32'(load_slot) < NUM_KEYS) begin
                     state_d            = StLoad;
                     slot_d             = load_slot;
                     ptr_d              = '0;
                     valid_d[load_slot] = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (din_valid) begin
                  err_d = 1'b1;
               end
            end
            StLoad: begin
               if (abort) begin
                  clr_load = 1'b1;
                  ptr_d    = '0;
                  state_d  = StIdle;
               end else begin
                  err_d = load_start;
                  if (din_valid) begin
                     wr_en = 1'b1;
                     if (32'(ptr_q) == KEY_BYTES - 1) begin
                        ptr_d           = '0;
                        valid_d[slot_q] = 1'b1;
                        done_d          = 1'b1;
                        state_d         = StIdle;
                     end else begin
                        ptr_d = ptr_q + BW'(1);
                     end
                  end
               end
            end
            StZero: begin
               clr_zero = 1'b1;
               err_d    = load_start | din_valid;
               if (32'(zidx_q) == NUM_KEYS - 1) begin
                  state_d = StIdle;
               end else begin
                  zidx_d = zidx_q + SW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Read path sees pre-edge storage and flags; invalid slots read as zero.
   always_comb begin
      rd_key      = '0;
      rd_byte_val = '0;
      if (32'(rd_slot) < NUM_KEYS && valid_q[rd_slot]) begin
         for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            rd_key[8*b +: 8] = mem_q[rd_slot][b];
         end
      end
      if (32'(rd_byte) < KEY_BYTES) begin
         rd_byte_val = rd_key[8*rd_byte +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         slot_q     <= '0;
         ptr_q      <= '0;
         zidx_q     <= '0;
         valid_q    <= '0;
         key_out_q  <= '0;
         byte_out_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int unsigned s = 0; s < NUM_KEYS; s++) begin
            for (int unsigned b = 0; b < KEY_BYTES; b++) begin
               mem_q[s][b] <= '0;
            end
         end
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         ptr_q      <= ptr_d;
         zidx_q     <= zidx_d;
         valid_q    <= valid_d;
         key_out_q  <= rd_key;
         byte_out_q <= rd_byte_val;
         done_q     <= done_d;
         err_q      <= err_d;
         if (wr_en) begin
            mem_q[slot_q][ptr_q] <= din;
         end
         if (clr_load) begin
            for (int unsigned b = 0; b < KEY_BYTES; b++) mem_q[slot_q][b] <= '0;
         end
         if (clr_zero) begin
            for (int unsigned b = 0; b < KEY_BYTES; b++) mem_q[zidx_q][b] <= '0;
         end
      end
   end

   assign key_out   = key_out_q;
   assign byte_out  = byte_out_q;
   assign key_valid = valid_q;
   assign busy      = (state_q != StIdle);
   assign load_done = done_q;
   assign load_err  = err_q;

endmodule

// File: tb/tb_key_bank.sv
// Bench for key_bank: directed load/abort/zeroize/error/reset scenarios checked against
// a transaction-level model every cycle, plus literal expectations at key points.
module tb_key_bank;

   localparam int NK = 4;
   localparam int KB = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  din = '0;
   logic        din_valid = 1'b0;
   logic        load_start = 1'b0;
   logic [1:0]  load_slot = '0;
   logic        abort = 1'b0;
   logic        zeroize = 1'b0;
   logic [1:0]  rd_slot = '0;
   logic [1:0]  rd_byte = '0;
   logic [31:0] key_out;
   logic [7:0]  byte_out;
   logic [3:0]  key_valid;
   logic        busy;
   logic        load_done;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   key_bank #(.NUM_KEYS(NK), .KEY_BYTES(KB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .load_start (load_start),
      .load_slot  (load_slot),
      .abort      (abort),
      .zeroize    (zeroize),
      .rd_slot    (rd_slot),
      .rd_byte    (rd_byte),
      .key_out    (key_out),
      .byte_out   (byte_out),
      .key_valid  (key_valid),
      .busy       (busy),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: mode 0 idle, 1 loading, 2 zeroizing; keys committed only on completion.
   int          mode = 0;
   int          m_slot = 0;
   int          m_cnt = 0;
   int          z_left = 0;
   logic [31:0] m_acc = '0;
   logic [31:0] m_key [NK];
   logic [3:0]  m_valid = '0;
   logic [31:0] e_key = '0;
   logic [7:0]  e_byte = '0;
   logic        e_done = 1'b0;
   logic        e_err = 1'b0;

   always @(posedge clk) begin
      logic [31:0] nk;
      logic [7:0]  nb;
      logic        nd, ne;
      nd = 1'b0;
      ne = 1'b0;
      nk = '0;
      nb = '0;
      if (!reset_n) begin
         mode    = 0;
         m_valid = '0;
         m_cnt   = 0;
      end else begin
         if (int'(rd_slot) < NK && m_valid[rd_slot]) nk = m_key[rd_slot];
         if (int'(rd_byte) < KB) nb = nk[8*rd_byte +: 8];
         if (zeroize) begin
            m_valid = '0;
            mode    = 2;
            z_left  = NK;
         end else if (mode == 0) begin
            if (abort) ne = 1'b1;
            else if (load_start) begin
               if (int'(load_slot) < NK) begin
                  mode               = 1;
                  m_slot             = int'(load_slot);
                  m_cnt              = 0;
                  m_acc              = '0;
                  m_valid[load_slot] = 1'b0;
               end else ne = 1'b1;
            end else if (din_valid) ne = 1'b1;
         end else if (mode == 1) begin
            if (abort) mode = 0;
            else begin
               if (load_start) ne = 1'b1;
               if (din_valid) begin
                  m_acc = m_acc | (32'(din) << (8 * m_cnt));
                  m_cnt++;
                  if (m_cnt == KB) begin
                     m_key[m_slot]   = m_acc;
                     m_valid[m_slot] = 1'b1;
                     nd              = 1'b1;
                     mode            = 0;
                  end
               end
            end
         end else begin
            if (load_start || din_valid) ne = 1'b1;
            z_left--;
            if (z_left == 0) mode = 0;
         end
      end
      e_key  = nk;
      e_byte = nb;
      e_done = nd;
      e_err  = ne;
      #1;
      check("key_out", key_out, e_key);
      check("byte_out", 32'(byte_out), 32'(e_byte));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(mode != 0));
      check("load_done", 32'(load_done), 32'(e_done));
      check("load_err", 32'(load_err), 32'(e_err));
   end

   task automatic load(input logic [1:0] slot, input logic [31:0] key, input int gap);
      load_start = 1'b1;
      load_slot  = slot;
      @(negedge clk);
      load_start = 1'b0;
      for (int b = 0; b < KB; b++) begin
         din       = key[8*b +: 8];
         din_valid = 1'b1;
         @(negedge clk);
         din_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      logic [31:0] partial;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_key_out", key_out, 32'h0);

      // Basic load of slot 2
      load(2'd2, 32'hDEADBEEF, 0);
      check("t1_done", 32'(load_done), 32'h1);
      check("t1_valid", 32'(key_valid), 32'h4);
      rd_slot = 2'd2;
      rd_byte = 2'd3;
      @(negedge clk);
      check("t1_key", key_out, 32'hDEADBEEF);
      check("t1_byte", 32'(byte_out), 32'hDE);
      check("t1_done_pulse", 32'(load_done), 32'h0);

      // Load, then abort a reload of the same slot
      load(2'd1, 32'h11223344, 0);
      partial    = 32'hAABBCCDD;
      load_start = 1'b1;
      load_slot  = 2'd1;
      @(negedge clk);
      load_start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         din       = partial[8*b +: 8];
         din_valid = 1'b1;
         @(negedge clk);
      end
      din_valid = 1'b0;
      abort     = 1'b1;
      @(negedge clk);
      abort   = 1'b0;
      rd_slot = 2'd1;
      @(negedge clk);
      check("t2_valid1", 32'(key_valid[1]), 32'h0);
      check("t2_key_zero", key_out, 32'h0);
      load(2'd1, 32'hCAFEF00D, 0);
      @(negedge clk);
      check("t2_key", key_out, 32'hCAFEF00D);
      check("t2_byte", 32'(byte_out), 32'hCA);

      // Zeroize after loading slots 0 and 3
      load(2'd0, 32'h01020304, 0);
      load(2'd3, 32'h05060708, 0);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check("t3_valid", 32'(key_valid), 32'h0);
      busy_cnt = busy ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         load_start = (i == 0);
         load_slot  = 2'd0;
         @(negedge clk);
         load_start = 1'b0;
         if (i == 0) check("t3_err", 32'(load_err), 32'h1);
         if (!busy) break;
         busy_cnt++;
      end
      check("t3_busy_cycles", 32'(busy_cnt), 32'd4);
      for (int s = 0; s < NK; s++) begin
         rd_slot = 2'(s);
         @(negedge clk);
         check("t3_read_zero", key_out, 32'h0);
      end

      // Protocol errors
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      check("t4_idle_err", 32'(load_err), 32'h1);
      check("t4_idle_busy", 32'(busy), 32'h0);
      load_start = 1'b1;
      load_slot  = 2'd0;
      @(negedge clk);
      load_start = 1'b0;
      din        = 8'h78;
      din_valid  = 1'b1;
      @(negedge clk);
      din_valid  = 1'b0;
      load_start = 1'b1;
      load_slot  = 2'd3;
      @(negedge clk);
      load_start = 1'b0;
      check("t4_load_err", 32'(load_err), 32'h1);
      check("t4_still_busy", 32'(busy), 32'h1);
      din       = 8'h56;
      din_valid = 1'b1;
      @(negedge clk);
      din = 8'h34;
      @(negedge clk);
      din = 8'h12;
      @(negedge clk);
      din_valid = 1'b0;
      check("t4_done", 32'(load_done), 32'h1);
      check("t4_valid", 32'(key_valid), 32'h1);
      rd_slot = 2'd0;
      rd_byte = 2'd1;
      @(negedge clk);
      check("t4_key", key_out, 32'h12345678);
      check("t4_byte", 32'(byte_out), 32'h56);

      // Gapped load
      load(2'd3, 32'h0BADF00D, 3);
      check("t5_valid", 32'(key_valid), 32'h9);
      rd_slot = 2'd3;
      rd_byte = 2'd0;
      @(negedge clk);
      check("t5_key", key_out, 32'h0BADF00D);
      check("t5_byte", 32'(byte_out), 32'h0D);

      // Asynchronous reset in the middle of a load
      load_start = 1'b1;
      load_slot  = 2'd2;
      @(negedge clk);
      load_start = 1'b0;
      din        = 8'h99;
      din_valid  = 1'b1;
      repeat (2) @(negedge clk);
      din_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_key_out", key_out, 32'h0);
      check("t6_byte_out", 32'(byte_out), 32'h0);
      check("t6_valid", 32'(key_valid), 32'h0);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_done", 32'(load_done), 32'h0);
      check("t6_err", 32'(load_err), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("t6_post_valid", 32'(key_valid), 32'h0);
      check("t6_post_busy", 32'(busy), 32'h0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
